dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, memory address width.
REQ-002 SHALL have parameter DW, default 32, memory data width.
REQ-003 SHALL have parameter EXT_MAX_WAIT, default 4: cycles the ext port may be refused before it is forced a grant.
REQ-004 SHALL have parameter LOCK_MAX, default 8: maximum consecutive cycles of ext lock ownership.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports cpu_req/cpu_we  in  1/1  pipeline MEM-stage access request / write flag.
REQ-008 SHALL have ports cpu_addr/cpu_wdata  in  AW/DW  pipeline access address / write data.
REQ-009 SHALL have ports cpu_rdata/cpu_stall  out  DW/1  read data / request to hold the pipeline this cycle.
REQ-010 SHALL have ports ext_req/ext_we/ext_lock  in  1/1/1  external (loader/debug) request / write flag / atomic-hold request.
REQ-011 SHALL have ports ext_addr/ext_wdata  in  AW/DW  external address / write data.
REQ-012 SHALL have ports ext_gnt/ext_rvalid/ext_rdata  out  1/1/DW  grant / read-data valid / read data.
REQ-013 SHALL have ports mem_addr/mem_data/mem_rden/mem_wren  out  AW/DW/1/1  data-memory address / write data / read enable / write enable.
REQ-014 SHALL have port mem_q  in  DW  data-memory read data, valid by the rising edge that ends the access cycle.

Function
REQ-015 SHALL implement states IDLE, LOCK and RELEASE, plus counters wait_cnt (0..EXT_MAX_WAIT, saturating) and lock_cnt (0..LOCK_MAX).
REQ-016 SHALL, in IDLE, set ext_gnt = ext_req & (~cpu_req | wait_cnt==EXT_MAX_WAIT); CPU has default priority.
REQ-017 SHALL, in LOCK, set ext_gnt = ext_req, giving ext absolute priority.
REQ-018 SHALL, in RELEASE, set ext_gnt = ext_req & ~cpu_req, for exactly one cycle.
REQ-019 SHALL compute cpu_gnt (internal) = cpu_req & ~ext_gnt & ~(state==LOCK); cpu_stall = cpu_req & ~cpu_gnt, combinational.
REQ-020 SHALL drive mem_* from the granted port (rden = ~we, wren = we) and drive all mem_* to 0 when neither port is granted.
REQ-021 SHALL pass cpu_rdata = mem_q combinationally (zero added latency for the pipeline).
REQ-022 SHALL complete an ext transfer at each rising edge with ext_req & ext_gnt; ext_addr, ext_we, ext_wdata and ext_lock are required stable while ext_req is high and ungranted.
REQ-023 SHALL register ext_rvalid high for exactly the cycle after a completed ext read, capturing ext_rdata = mem_q at that edge; ext_rdata holds its value until the next completed ext read.
REQ-024 SHALL increment wait_cnt when ext_req & ~ext_gnt (saturating) and clear it on ext_gnt or ~ext_req.
REQ-025 SHALL take IDLE->LOCK on a completed ext transfer with ext_lock=1, loading lock_cnt=1.
REQ-026 SHALL, in LOCK, increment lock_cnt each cycle; on ext_lock=0 go to IDLE; on lock_cnt==LOCK_MAX with ext_lock=1 go to RELEASE (forced release); ext_lock=0 takes precedence when both hold.
REQ-027 SHALL, in LOCK, stall the CPU even when ext_req is low (bus held idle, mem_* = 0).
REQ-028 SHALL take RELEASE->IDLE unconditionally after one cycle; ext_lock is ignored in RELEASE.
REQ-029 SHALL grant the ext port when both ports request in the same cycle only when wait_cnt==EXT_MAX_WAIT or state==LOCK.

Reset
REQ-030 SHALL, while rst=1, force state=IDLE, wait_cnt=0, lock_cnt=0, ext_rvalid=0, ext_rdata=0, ext_gnt=0, cpu_stall=0 and all mem_*=0.
REQ-031 SHALL abandon any lock or pending ext read on reset mid-operation; no ext_rvalid pulse follows reset.

Verification
REQ-032 SHALL be tested: cpu_req read addr 0x10 alone with mem_q=0x12345678 -> cpu_stall=0, mem_rden=1, mem_addr=0x10, cpu_rdata=0x12345678 same cycle.
REQ-033 SHALL be tested: cpu_req and ext_req held continuously -> ext refused 4 cycles (cpu_stall=0), ext_gnt=1 and cpu_stall=1 on cycle 5, then wait_cnt returns to 0.
REQ-034 SHALL be tested: ext read addr 0x20 with mem_q=0xCAFEF00D -> ext_rvalid=1 for exactly one cycle on the next cycle, ext_rdata=0xCAFEF00D held afterwards.
REQ-035 SHALL be tested: ext_lock=1 held, cpu_req continuously -> LOCK for 8 cycles with cpu_stall=1, then RELEASE with cpu granted and ext_gnt=0, then IDLE.
REQ-036 SHALL be tested: rst asserted in LOCK with an ext read just completed -> next cycle state=IDLE, ext_rvalid=0, cpu_stall=0.
REQ-037 SHALL be tested: ext write addr 0x05 data 0xA5A5A5A5 -> mem_wren=1, mem_rden=0, mem_data=0xA5A5A5A5 in the grant cycle and no ext_rvalid pulse.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: pipeline MEM stage vs. external loader/debug port, with bounded ext wait and lock.
// Zero added latency on the CPU path; ext read data one cycle after grant; losers are held via cpu_stall / ~ext_gnt.
module dmem_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 32,
   parameter int EXT_MAX_WAIT = 4,
   parameter int LOCK_MAX     = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic          ext_lock,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic          ext_gnt,
   output logic          ext_rvalid,
   output logic [DW-1:0] ext_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   output logic          mem_rden,
   output logic          mem_wren,
   input  logic [DW-1:0] mem_q
);

   localparam int WW = (EXT_MAX_WAIT < 1) ? 1 : $clog2(EXT_MAX_WAIT + 1);
   localparam int LW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
   localparam logic [WW-1:0] WAIT_TOP = WW'(EXT_MAX_WAIT);
   localparam logic [WW-1:0] WAIT_ONE = WW'(1);
   localparam logic [LW-1:0] LOCK_TOP = LW'(LOCK_MAX);
   localparam logic [LW-1:0] LOCK_ONE = LW'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCK    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [WW-1:0] wait_cnt, wait_nxt;
   logic [LW-1:0] lock_cnt, lock_nxt;
   logic          cpu_gnt;
   logic          ext_xfer;
   logic          wait_sat;
   logic          rvalid_q;
   logic [DW-1:0] rdata_q;

   assign wait_sat  = (wait_cnt == WAIT_TOP);
   assign cpu_rdata = mem_q;

   // Registered read-return outputs are also held low for the whole reset cycle.
   assign ext_rvalid = rvalid_q & ~rst;
   assign ext_rdata  = rst ? '0 : rdata_q;

   always_comb begin
      ext_gnt   = 1'b0;
      cpu_gnt   = 1'b0;
      cpu_stall = 1'b0;
      ext_xfer  = 1'b0;
      mem_addr  = '0;
      mem_data  = '0;
      mem_rden  = 1'b0;
      mem_wren  = 1'b0;
      state_nxt = state;
      wait_nxt  = wait_cnt;
      lock_nxt  = lock_cnt;

      if (!rst) begin
         case (state)
            IDLE:    ext_gnt = ext_req & (~cpu_req | wait_sat);
            LOCK:    ext_gnt = ext_req;
            RELEASE: ext_gnt = ext_req & ~cpu_req;
            default: ext_gnt = 1'b0;
         endcase
         cpu_gnt   = cpu_req & ~ext_gnt & (state != LOCK);
         cpu_stall = cpu_req & ~cpu_gnt;
      end
      ext_xfer = ext_req & ext_gnt;

      if (ext_gnt) begin
         mem_addr = ext_addr;
         mem_data = ext_wdata;
         mem_rden = ~ext_we;
         mem_wren = ext_we;
      end else if (cpu_gnt) begin
         mem_addr = cpu_addr;
         mem_data = cpu_wdata;
         mem_rden = ~cpu_we;
         mem_wren = cpu_we;
      end

      if (ext_req && !ext_gnt) begin
         wait_nxt = wait_sat ? wait_cnt : wait_cnt + WAIT_ONE;
      end else begin
         wait_nxt = '0;
      end

      case (state)
         IDLE: begin
            if (ext_xfer && ext_lock) begin
               state_nxt = LOCK;
               lock_nxt  = LOCK_ONE;
            end
         end
         LOCK: begin
            // Dropping the lock wins over the forced release.
            if (!ext_lock) begin
               state_nxt = IDLE;
               lock_nxt  = '0;
            end else if (lock_cnt == LOCK_TOP) begin
               state_nxt = RELEASE;
               lock_nxt  = '0;
            end else begin
               lock_nxt  = lock_cnt + LOCK_ONE;
            end
         end
         RELEASE: begin
            state_nxt = IDLE;
            lock_nxt  = '0;
         end
         default: begin
            state_nxt = IDLE;
            lock_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         lock_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         lock_cnt <= lock_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= ext_xfer & ~ext_we;
         if (ext_xfer && !ext_we) begin
            rdata_q <= mem_q;
         end
      end
   end

   a_one_enable: assert property (@(posedge clk) disable iff (rst) !(mem_rden && mem_wren));
   a_one_grant:  assert property (@(posedge clk) disable iff (rst) !(ext_gnt && cpu_gnt));

endmodule
